multi_edge_pulser: RTL and testbench



---
 rtl/mep_pkg.sv | 28 ++
 rtl/mep_channel.sv | 146 ++++++++++++++
 rtl/multi_edge_pulser.sv | 47 ++++
 tb/tb_multi_edge_pulser.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mep_pkg.sv
// Shared types, edge-type encodings and packed-parameter slicing for multi_edge_pulser.
package mep_pkg;

    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_BOTH = 2'd2;

    // Widest packed parameter vector the slicer accepts.
    localparam int unsigned SLICE_VEC_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLD
    } state_t;

    // Extract field idx of width w (w <= 32) from a packed parameter vector.
    function automatic logic [31:0] slice_field(input logic [SLICE_VEC_W-1:0] vec,
                                                input int unsigned idx,
                                                input int unsigned w);
        logic [SLICE_VEC_W-1:0] shifted;
        logic [31:0]            mask;
        shifted = vec >> (idx * w);
        mask    = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return 32'(shifted) & mask;
    endfunction

endpackage

// File: rtl/mep_channel.sv
// One channel: input synchroniser, edge detect and IDLE/PULSE/HOLD pulse stretcher.
module mep_channel
    import mep_pkg::*;
#(
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      CNT_W           = 8,
    parameter logic [CNT_W-1:0] PULSE_LEN       = CNT_W'(1),
    parameter logic [CNT_W-1:0] HOLDOFF         = '0,
    parameter logic [1:0]       EDGE_TYPE       = EDGE_RISE,
    parameter bit               RETRIGGER       = 1'b0,
    parameter bit               CLR_IGNORE_BUSY = 1'b1,
    parameter bit               INIT_LEVEL      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sig_in,
    output logic pulse_out,
    output logic busy,
    output logic edge_seen,
    output logic dropped
);

    // A zero pulse length behaves as a single-cycle pulse.
    localparam logic [CNT_W-1:0] RELOAD    = (PULSE_LEN == '0) ? '0 : PULSE_LEN - CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF == '0) ? '0 : HOLDOFF - CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   det_sel;
    logic                   det;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             skip_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
            prev_q <= INIT_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    always_comb begin
        det_sel = rise;
        case (EDGE_TYPE)
            EDGE_FALL: det_sel = fall;
            EDGE_BOTH: det_sel = rise | fall;
            default:   det_sel = rise;
        endcase
    end

    // prev_q keeps tracking s during clr, so edges arriving then are discarded.
    assign det = det_sel & ~clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            skip_hold <= 1'b0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            edge_seen <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            edge_seen <= 1'b0;
            dropped   <= 1'b0;
            if (clr) begin
                if (state == PULSE && CLR_IGNORE_BUSY) begin
                    // Let the pulse run out, then return straight to IDLE.
                    skip_hold <= 1'b1;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state     <= IDLE;
                        pulse_out <= 1'b0;
                        busy      <= 1'b0;
                    end
                end else begin
                    state     <= IDLE;
                    cnt       <= '0;
                    skip_hold <= 1'b0;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (det) begin
                            state     <= PULSE;
                            cnt       <= RELOAD;
                            skip_hold <= 1'b0;
                            pulse_out <= 1'b1;
                            busy      <= 1'b1;
                            edge_seen <= 1'b1;
                        end
                    end
                    PULSE: begin
                        if (det && RETRIGGER) begin
                            cnt       <= RELOAD;
                            edge_seen <= 1'b1;
                        end else if (cnt != '0) begin
                            cnt     <= cnt - CNT_W'(1);
                            dropped <= det;
                        end else begin
                            dropped   <= det;
                            pulse_out <= 1'b0;
                            if (skip_hold || HOLDOFF == '0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= HOLD;
                                cnt   <= HOLD_LOAD;
                            end
                        end
                    end
                    HOLD: begin
                        dropped <= det;
                        if (cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        pulse_out <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_edge_pulser.sv
// N-channel edge detector / pulse stretcher feeding the HPS reset-request inputs.
module multi_edge_pulser
    import mep_pkg::*;
#(
    parameter int unsigned            NCH             = 3,
    parameter int unsigned            SYNC_STAGES     = 2,
    parameter int unsigned            CNT_W           = 8,
    parameter logic [NCH*CNT_W-1:0]   PULSE_LEN       = {8'd32, 8'd2, 8'd6},
    parameter logic [NCH*CNT_W-1:0]   HOLDOFF         = '0,
    parameter logic [NCH*2-1:0]       EDGE_TYPE       = '0,
    parameter logic [NCH-1:0]         RETRIGGER       = '0,
    parameter logic [NCH-1:0]         CLR_IGNORE_BUSY = '1,
    parameter logic [NCH-1:0]         INIT_LEVEL      = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic [NCH-1:0] sig_in,
    output logic [NCH-1:0] pulse_out,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] edge_seen,
    output logic [NCH-1:0] dropped
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mep_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .CNT_W           (CNT_W),
            .PULSE_LEN       (CNT_W'(slice_field(SLICE_VEC_W'(PULSE_LEN), i, CNT_W))),
            .HOLDOFF         (CNT_W'(slice_field(SLICE_VEC_W'(HOLDOFF), i, CNT_W))),
            .EDGE_TYPE       (2'(slice_field(SLICE_VEC_W'(EDGE_TYPE), i, 2))),
            .RETRIGGER       (RETRIGGER[i]),
            .CLR_IGNORE_BUSY (CLR_IGNORE_BUSY[i]),
            .INIT_LEVEL      (INIT_LEVEL[i])
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .sig_in    (sig_in[i]),
            .pulse_out (pulse_out[i]),
            .busy      (busy[i]),
            .edge_seen (edge_seen[i]),
            .dropped   (dropped[i])
        );
    end

endmodule

// File: tb/tb_multi_edge_pulser.sv
// Scoreboard bench for multi_edge_pulser: three differently configured instances, per-cycle expectations.
module tb_multi_edge_pulser;

    localparam int F_PULSE = 0;
    localparam int F_BUSY  = 1;
    localparam int F_ES    = 2;
    localparam int F_DROP  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr0, clr1, clr2;
    logic [2:0] sig0, pulse0, busy0, es0, drop0;
    logic [3:0] sig1, pulse1, busy1, es1, drop1;
    logic [2:0] sig2, pulse2, busy2, es2, drop2;

    typedef struct {
        int          cyc;
        int          inst;
        logic [63:0] tag;
        logic [15:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          cyc   = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] win [32];
    int          win_base;
    int          win_inst;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Defaults: ch0 len 6, ch1 len 2, ch2 len 32, rising, no holdoff.
    multi_edge_pulser u0 (
        .clk(clk), .rst(rst), .clr(clr0), .sig_in(sig0),
        .pulse_out(pulse0), .busy(busy0), .edge_seen(es0), .dropped(drop0)
    );

    // ch0 len 6 clr truncates; ch1 both edges len 2; ch2 retrigger len 4; ch3 len 2 holdoff 5.
    multi_edge_pulser #(
        .NCH(4), .PULSE_LEN({8'd2, 8'd4, 8'd2, 8'd6}), .HOLDOFF({8'd5, 8'd0, 8'd0, 8'd0}),
        .EDGE_TYPE(8'b00_00_10_00), .RETRIGGER(4'b0100), .CLR_IGNORE_BUSY(4'b1110),
        .INIT_LEVEL(4'b0000)
    ) u1 (
        .clk(clk), .rst(rst), .clr(clr1), .sig_in(sig1),
        .pulse_out(pulse1), .busy(busy1), .edge_seen(es1), .dropped(drop1)
    );

    // ch0 init high len 3; ch1 len 6 holdoff 4 clr-ignoring; ch2 falling, len 0.
    multi_edge_pulser #(
        .NCH(3), .PULSE_LEN({8'd0, 8'd6, 8'd3}), .HOLDOFF({8'd0, 8'd4, 8'd0}),
        .EDGE_TYPE(6'b01_00_00), .RETRIGGER(3'b000), .CLR_IGNORE_BUSY(3'b111),
        .INIT_LEVEL(3'b001)
    ) u2 (
        .clk(clk), .rst(rst), .clr(clr2), .sig_in(sig2),
        .pulse_out(pulse2), .busy(busy2), .edge_seen(es2), .dropped(drop2)
    );

    function automatic logic [15:0] observe(input int inst);
        case (inst)
            0:       return {1'b0, drop0, 1'b0, es0, 1'b0, busy0, 1'b0, pulse0};
            1:       return {drop1, es1, busy1, pulse1};
            default: return {1'b0, drop2, 1'b0, es2, 1'b0, busy2, 1'b0, pulse2};
        endcase
    endfunction

    task automatic check(input logic [63:0] tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %0s cyc=%0d got={drop,es,busy,pulse}=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // Compare every expectation due this cycle; the vector is {dropped, edge_seen, busy, pulse_out}.
    always @(negedge clk) begin
        int k;
        k = 0;
        while (k < sb.size()) begin
            if (sb[k].cyc <= cyc) begin
                check(sb[k].tag, observe(sb[k].inst), sb[k].exp);
                sb.delete(k);
            end else begin
                k++;
            end
        end
    end

    task automatic open_win(input int inst, input int base);
        win_inst = inst;
        win_base = base;
        for (int i = 0; i < 32; i++) win[i] = '0;
    endtask

    task automatic mark(input int field, input int ch, input int from, input int to);
        for (int c = from; c <= to; c++) win[c - win_base][field*4 + ch] = 1'b1;
    endtask

    task automatic push_win(input logic [63:0] tag, input int len);
        for (int i = 0; i < len; i++) begin
            exp_t e;
            e.cyc  = win_base + i;
            e.inst = win_inst;
            e.tag  = tag;
            e.exp  = win[i];
            sb.push_back(e);
        end
    endtask

    // Return just after the posedge that makes cyc == n.
    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
        sig0 = '0;   sig1 = '0;   sig2 = 3'b001;

        for (int inst = 0; inst < 3; inst++) begin
            open_win(inst, 1);
            push_win("reset", 9);
        end
        wait_cyc(3);
        rst = 1'b0;

        // Plain rising edge, 6-cycle pulse, later fall ignored.
        wait_cyc(10);
        open_win(0, 10);
        mark(F_PULSE, 0, 13, 18); mark(F_BUSY, 0, 13, 18); mark(F_ES, 0, 13, 13);
        push_win("rise_c0", 13);
        sig0[0] = 1'b1;
        wait_cyc(20); sig0[0] = 1'b0;

        // Both-edge channel: two 2-cycle pulses.
        wait_cyc(30);
        open_win(1, 30);
        mark(F_PULSE, 1, 33, 34); mark(F_BUSY, 1, 33, 34); mark(F_ES, 1, 33, 33);
        mark(F_PULSE, 1, 43, 44); mark(F_BUSY, 1, 43, 44); mark(F_ES, 1, 43, 43);
        push_win("both_c1", 19);
        sig1[1] = 1'b1;
        wait_cyc(40); sig1[1] = 1'b0;

        // Retrigger 3 cycles into a 4-cycle pulse gives 7 continuous cycles.
        wait_cyc(50);
        open_win(1, 50);
        mark(F_PULSE, 2, 53, 59); mark(F_BUSY, 2, 53, 59);
        mark(F_ES, 2, 53, 53); mark(F_ES, 2, 56, 56);
        push_win("retrig", 17);
        sig1[2] = 1'b1;
        wait_cyc(51); sig1[2] = 1'b0;
        wait_cyc(53); sig1[2] = 1'b1;
        wait_cyc(62); sig1[2] = 1'b0;

        // Holdoff: edges detected at +0, +2, +9 -> accept, drop, accept.
        wait_cyc(70);
        open_win(1, 70);
        mark(F_PULSE, 3, 73, 74); mark(F_BUSY, 3, 73, 79); mark(F_ES, 3, 73, 73);
        mark(F_DROP, 3, 75, 75);
        mark(F_PULSE, 3, 82, 83); mark(F_BUSY, 3, 82, 88); mark(F_ES, 3, 82, 82);
        push_win("holdoff", 23);
        sig1[3] = 1'b1;
        wait_cyc(71); sig1[3] = 1'b0;
        wait_cyc(72); sig1[3] = 1'b1;
        wait_cyc(73); sig1[3] = 1'b0;
        wait_cyc(79); sig1[3] = 1'b1;
        wait_cyc(90); sig1[3] = 1'b0;

        // clr truncates a pulse on a non-ignoring channel.
        wait_cyc(100);
        open_win(1, 100);
        mark(F_PULSE, 0, 103, 104); mark(F_BUSY, 0, 103, 104); mark(F_ES, 0, 103, 103);
        push_win("clr_trunc", 13);
        sig1[0] = 1'b1;
        wait_cyc(104); clr1 = 1'b1;
        wait_cyc(106); clr1 = 1'b0;
        wait_cyc(108); sig1[0] = 1'b0;

        // clr on an ignoring channel: full pulse, no holdoff, edge during clr lost.
        wait_cyc(120);
        open_win(2, 120);
        mark(F_PULSE, 1, 123, 128); mark(F_BUSY, 1, 123, 128); mark(F_ES, 1, 123, 123);
        push_win("clr_keep", 15);
        sig2[1] = 1'b1;
        wait_cyc(121); sig2[1] = 1'b0;
        wait_cyc(123); sig2[1] = 1'b1;
        wait_cyc(124); clr2 = 1'b1;
        wait_cyc(127); clr2 = 1'b0;
        wait_cyc(135); sig2[1] = 1'b0;

        // Init-high channel: held level gave no pulse; fall then rise gives one.
        wait_cyc(138);
        open_win(2, 138);
        mark(F_PULSE, 0, 148, 150); mark(F_BUSY, 0, 148, 150); mark(F_ES, 0, 148, 148);
        push_win("init_hi", 17);
        wait_cyc(140); sig2[0] = 1'b0;
        wait_cyc(145); sig2[0] = 1'b1;

        // Falling-edge channel with zero length: single-cycle pulse.
        wait_cyc(160);
        open_win(2, 160);
        mark(F_PULSE, 2, 165, 165); mark(F_BUSY, 2, 165, 165); mark(F_ES, 2, 165, 165);
        push_win("len0_fall", 9);
        sig2[2] = 1'b1;
        wait_cyc(162); sig2[2] = 1'b0;

        // Async reset mid-pulse kills it; input still high vs init low re-triggers.
        wait_cyc(170);
        open_win(0, 170);
        mark(F_PULSE, 2, 173, 179); mark(F_BUSY, 2, 173, 179); mark(F_ES, 2, 173, 173);
        mark(F_PULSE, 2, 185, 190); mark(F_BUSY, 2, 185, 190); mark(F_ES, 2, 185, 185);
        push_win("rst_mid", 21);
        sig0[2] = 1'b1;
        wait_cyc(180); rst = 1'b1;
        wait_cyc(182); rst = 1'b0;

        wait_cyc(195);
        check("sb_empty", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
